// File: rtl/id_imm_stage.sv
// RV32I immediate/format decode stage behind a two-entry skid buffer (main + skid).
// Optional: define IMM_ILLEGAL_CHK_EN to add the registered out_illegal flag.
module id_imm_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
`ifdef IMM_ILLEGAL_CHK_EN
    output logic            out_illegal,
`endif
    output logic [2:0]      out_fmt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;

    logic [6:0]      w_opcode;
    logic [2:0]      w_dec_fmt;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_main_load;

    logic            r_main_valid;
    logic [XLEN-1:0] r_main_instr;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_imm;
    logic [2:0]      r_main_fmt;

    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;

    assign w_opcode = in_instr[6:0];

    // Decode on the input side so the registered immediate drives out_imm directly.
    always_comb begin
        w_dec_fmt = FMT_UNK;
        w_dec_imm = '0;
        case (w_opcode)
            7'b0110011: begin
                w_dec_fmt = FMT_R;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w_dec_fmt = FMT_I;
                w_dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                w_dec_fmt = FMT_S;
                w_dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_dec_fmt = FMT_B;
                w_dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_dec_fmt = FMT_U;
                w_dec_imm = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_dec_fmt = FMT_J;
                w_dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                w_dec_fmt = FMT_UNK;
                w_dec_imm = '0;
            end
        endcase
    end

    // in_ready depends only on skid occupancy, never on out_ready.
    assign in_ready    = ~r_skid_valid;
    assign w_in_fire   = in_valid & ~r_skid_valid;
    assign w_out_fire  = r_main_valid & out_ready;
    assign w_main_load = ~r_main_valid | w_out_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_main_imm   <= '0;
            r_main_fmt   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            // A full skid implies in_ready=0, so nothing new arrives while it moves up.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_instr <= in_instr;
                    r_main_pc    <= in_pc;
                    r_main_imm   <= w_dec_imm;
                    r_main_fmt   <= w_dec_fmt;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_skid_imm   <= w_dec_imm;
            r_skid_fmt   <= w_dec_fmt;
        end
    end

`ifdef IMM_ILLEGAL_CHK_EN
    logic r_main_ill;
    logic r_skid_ill;

    // Illegal flag travels with its entry, mirroring the data path above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ill <= 1'b0;
            r_skid_ill <= 1'b0;
        end else if (!flush) begin
            if (w_main_load) begin
                if (r_skid_valid) begin
                    r_main_ill <= r_skid_ill;
                end else if (w_in_fire) begin
                    r_main_ill <= (w_dec_fmt == FMT_UNK);
                end
            end else if (w_in_fire) begin
                r_skid_ill <= (w_dec_fmt == FMT_UNK);
            end
        end
    end

    assign out_illegal = r_main_ill;
`endif

    assign out_valid = r_main_valid;
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
    assign out_imm   = r_main_imm;
    assign out_fmt   = r_main_fmt;

endmodule
